// File: rtl/id_stage_pipe.sv
// RV32I decode stage: regfile, imm gen, control, branch resolve,
// registered ID/EX with backpressure, load-use stall and kill slot.
module id_stage_pipe #(
  parameter int NUM_REG        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_WIDTH      = 32,
  parameter int PC_WIDTH       = 32,
  parameter int INST_WIDTH     = 32,
  parameter int LOAD_STALL     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [PC_WIDTH-1:0]       if_pc,
  input  logic [INST_WIDTH-1:0]     if_inst,
  input  logic                      wb_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [REG_WIDTH-1:0]      wb_data,
  input  logic [1:0]                fwd_sel1,
  input  logic [1:0]                fwd_sel2,
  input  logic [REG_WIDTH-1:0]      ex_alu_out,
  input  logic [REG_WIDTH-1:0]      mem_data,
  input  logic                      ex_ready,
  output logic                      redirect,
  output logic [PC_WIDTH-1:0]       redirect_pc,
  output logic                      id_ex_valid,
  output logic [PC_WIDTH-1:0]       id_ex_pc,
  output logic [REG_WIDTH-1:0]      id_ex_rs1_data,
  output logic [REG_WIDTH-1:0]      id_ex_rs2_data,
  output logic [REG_WIDTH-1:0]      id_ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_rd,
  output logic [3:0]                id_ex_alu_op,
  output logic                      id_ex_asel,
  output logic                      id_ex_bsel,
  output logic                      id_ex_mem_rd,
  output logic                      id_ex_mem_wr,
  output logic                      id_ex_reg_wr,
  output logic [1:0]                id_ex_wb_sel
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL - 1);

  logic [REG_WIDTH-1:0]      r_rf [NUM_REG];
  logic                      r_v, r_asel, r_bsel, r_mrd, r_mwr, r_rwr;
  logic [PC_WIDTH-1:0]       r_pc;
  logic [REG_WIDTH-1:0]      r_a, r_b, r_imm;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [3:0]                r_alu, r_stall;
  logic [1:0]                r_wb;
  logic                      r_kill;

  logic [6:0]                w_op;
  logic [2:0]                w_f3;
  logic [REG_ADDR_WIDTH-1:0] w_rs1, w_rs2, w_rd;
  logic [REG_WIDTH-1:0]      w_rf1, w_rf2, w_op1, w_op2, w_imm;
  logic [REG_WIDTH-1:0]      w_jr_sum;
  logic [PC_WIDTH-1:0]       w_br_tgt, w_jr_tgt, w_tgt;
  logic [3:0]                w_alu;
  logic [1:0]                w_wb;
  logic                      w_asel, w_bsel, w_mrd, w_mwr, w_rwr;
  logic                      w_use1, w_use2, w_br, w_jal, w_jr;
  logic                      w_taken, w_jump, w_hazard, w_accept;

  assign w_op  = if_inst[6:0];
  assign w_f3  = if_inst[14:12];
  assign w_rd  = REG_ADDR_WIDTH'(if_inst[11:7]);
  assign w_rs1 = REG_ADDR_WIDTH'(if_inst[19:15]);
  assign w_rs2 = REG_ADDR_WIDTH'(if_inst[24:20]);

  // Write-first: a same-cycle writeback is visible to this read
  assign w_rf1 = (w_rs1 == '0) ? '0 :
                 (wb_wr_en && wb_rd == w_rs1) ? wb_data : r_rf[w_rs1];
  assign w_rf2 = (w_rs2 == '0) ? '0 :
                 (wb_wr_en && wb_rd == w_rs2) ? wb_data : r_rf[w_rs2];

  always_comb begin
    w_op1 = w_rf1;
    unique case (fwd_sel1)
      2'b00: w_op1 = w_rf1;
      2'b01: w_op1 = ex_alu_out;
      2'b10: w_op1 = mem_data;
      2'b11: w_op1 = wb_data;
    endcase
    w_op2 = w_rf2;
    unique case (fwd_sel2)
      2'b00: w_op2 = w_rf2;
      2'b01: w_op2 = ex_alu_out;
      2'b10: w_op2 = mem_data;
      2'b11: w_op2 = wb_data;
    endcase
  end

  always_comb begin
    w_imm  = '0;
    w_alu  = '0;
    w_asel = 1'b0;
    w_bsel = 1'b0;
    w_mrd  = 1'b0;
    w_mwr  = 1'b0;
    w_rwr  = 1'b0;
    w_wb   = 2'b00;
    w_use1 = 1'b1;
    w_use2 = 1'b0;
    w_br   = 1'b0;
    w_jal  = 1'b0;
    w_jr   = 1'b0;
    unique case (w_op)
      OP_R: begin
        w_alu  = {if_inst[30], w_f3};
        w_rwr  = 1'b1;
        w_use2 = 1'b1;
      end
      OP_I: begin
        w_imm  = REG_WIDTH'($signed(if_inst[31:20]));
        w_alu  = {(w_f3 == 3'b101) & if_inst[30], w_f3};
        w_bsel = 1'b1;
        w_rwr  = 1'b1;
      end
      OP_LD: begin
        w_imm  = REG_WIDTH'($signed(if_inst[31:20]));
        w_bsel = 1'b1;
        w_mrd  = 1'b1;
        w_rwr  = 1'b1;
        w_wb   = 2'b01;
      end
      OP_ST: begin
        w_imm  = REG_WIDTH'($signed({if_inst[31:25], if_inst[11:7]}));
        w_bsel = 1'b1;
        w_mwr  = 1'b1;
        w_use2 = 1'b1;
      end
      OP_BR: begin
        w_imm  = REG_WIDTH'($signed({if_inst[31], if_inst[7],
                   if_inst[30:25], if_inst[11:8], 1'b0}));
        w_use2 = 1'b1;
        w_br   = 1'b1;
      end
      OP_JAL: begin
        w_imm  = REG_WIDTH'($signed({if_inst[31], if_inst[19:12],
                   if_inst[20], if_inst[30:21], 1'b0}));
        w_asel = 1'b1;
        w_bsel = 1'b1;
        w_rwr  = 1'b1;
        w_wb   = 2'b10;
        w_use1 = 1'b0;
        w_jal  = 1'b1;
      end
      OP_JR: begin
        w_imm  = REG_WIDTH'($signed(if_inst[31:20]));
        w_bsel = 1'b1;
        w_rwr  = 1'b1;
        w_wb   = 2'b10;
        w_jr   = 1'b1;
      end
      OP_LUI: begin
        w_imm  = REG_WIDTH'($signed({if_inst[31:12], 12'b0}));
        w_bsel = 1'b1;
        w_rwr  = 1'b1;
        w_use1 = 1'b0;
      end
      OP_AUI: begin
        w_imm  = REG_WIDTH'($signed({if_inst[31:12], 12'b0}));
        w_asel = 1'b1;
        w_bsel = 1'b1;
        w_rwr  = 1'b1;
        w_use1 = 1'b0;
      end
      default: w_use1 = 1'b0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    unique case (w_f3)
      3'b000:  w_taken = (w_op1 == w_op2);
      3'b001:  w_taken = (w_op1 != w_op2);
      3'b100:  w_taken = ($signed(w_op1) < $signed(w_op2));
      3'b101:  w_taken = ($signed(w_op1) >= $signed(w_op2));
      3'b110:  w_taken = (w_op1 < w_op2);
      3'b111:  w_taken = (w_op1 >= w_op2);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_br_tgt = if_pc + PC_WIDTH'(w_imm);
  assign w_jr_sum = w_op1 + w_imm;
  assign w_jr_tgt = {w_jr_sum[PC_WIDTH-1:1], 1'b0};
  assign w_tgt    = w_jr ? w_jr_tgt : w_br_tgt;
  assign w_jump   = (w_br & w_taken) | w_jal | w_jr;

  assign w_hazard = r_v & r_mrd & (r_rd != '0) &
                    ((w_use1 & (w_rs1 == r_rd)) |
                     (w_use2 & (w_rs2 == r_rd)));
  assign if_ready = ~w_hazard & (r_stall == '0) & (ex_ready | ~r_v);
  assign w_accept = if_valid & if_ready;

  assign redirect    = w_accept & ~r_kill & w_jump;
  assign redirect_pc = redirect ? w_tgt : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REG; i++) r_rf[i] <= '0;
    end else if (wb_wr_en && wb_rd != '0) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v     <= 1'b0;
      r_pc    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
      r_alu   <= '0;
      r_asel  <= 1'b0;
      r_bsel  <= 1'b0;
      r_mrd   <= 1'b0;
      r_mwr   <= 1'b0;
      r_rwr   <= 1'b0;
      r_wb    <= 2'b00;
      r_stall <= '0;
      r_kill  <= 1'b0;
    end else begin
      if (w_accept && !r_kill) begin
        r_v    <= 1'b1;
        r_pc   <= if_pc;
        r_a    <= w_op1;
        r_b    <= w_op2;
        r_imm  <= w_imm;
        r_rd   <= w_rwr ? w_rd : '0;
        r_alu  <= w_alu;
        r_asel <= w_asel;
        r_bsel <= w_bsel;
        r_mrd  <= w_mrd;
        r_mwr  <= w_mwr;
        r_rwr  <= w_rwr;
        r_wb   <= w_wb;
      end else if (ex_ready) begin
        r_v <= 1'b0;
      end
      if (w_hazard && ex_ready) r_stall <= STALL_INIT;
      else if (r_stall != '0 && ex_ready) r_stall <= r_stall - 4'd1;
      // The slot after a redirect is fetched down the wrong path
      if (redirect) r_kill <= 1'b1;
      else if (w_accept) r_kill <= 1'b0;
    end
  end

  assign id_ex_valid    = r_v;
  assign id_ex_pc       = r_pc;
  assign id_ex_rs1_data = r_a;
  assign id_ex_rs2_data = r_b;
  assign id_ex_imm      = r_imm;
  assign id_ex_rd       = r_rd;
  assign id_ex_alu_op   = r_alu;
  assign id_ex_asel     = r_asel;
  assign id_ex_bsel     = r_bsel;
  assign id_ex_mem_rd   = r_mrd;
  assign id_ex_mem_wr   = r_mwr;
  assign id_ex_reg_wr   = r_rwr;
  assign id_ex_wb_sel   = r_wb;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus a random stream
// scored against an instruction-level model of RV32I decode.
module tb_id_stage_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        asel;
    logic        bsel;
    logic        mrd;
    logic        mwr;
    logic        rwr;
    logic [1:0]  wb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        wb_wr_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [1:0]  fwd_sel1 = '0;
  logic [1:0]  fwd_sel2 = '0;
  logic [31:0] ex_alu_out = '0;
  logic [31:0] mem_data = '0;
  logic        ex_ready = 1'b1;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rd;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_asel, id_ex_bsel;
  logic        id_ex_mem_rd, id_ex_mem_wr, id_ex_reg_wr;
  logic [1:0]  id_ex_wb_sel;

  id_stage_pipe #(.LOAD_STALL(2)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .ex_alu_out(ex_alu_out), .mem_data(mem_data),
    .ex_ready(ex_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_imm(id_ex_imm), .id_ex_rd(id_ex_rd),
    .id_ex_alu_op(id_ex_alu_op),
    .id_ex_asel(id_ex_asel), .id_ex_bsel(id_ex_bsel),
    .id_ex_mem_rd(id_ex_mem_rd), .id_ex_mem_wr(id_ex_mem_wr),
    .id_ex_reg_wr(id_ex_reg_wr), .id_ex_wb_sel(id_ex_wb_sel)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        q[$];
  logic [31:0] rf [32];
  logic        m_kill = 1'b0;
  logic        obs_ready, obs_redir;
  logic [31:0] obs_rpc;

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rdrf(input logic [4:0] r);
    if (r == 0) return 0;
    if (wb_wr_en && wb_rd == r) return wb_data;
    return rf[r];
  endfunction

  function automatic logic [31:0] fwdv(input logic [1:0] s,
                                       input logic [31:0] v);
    case (s)
      2'd1: return ex_alu_out;
      2'd2: return mem_data;
      2'd3: return wb_data;
      default: return v;
    endcase
  endfunction

  // Architectural meaning of one instruction
  function automatic void model(input logic [31:0] in, pc, a, b,
                                output exp_t e, output logic jmp,
                                output logic [31:0] tgt);
    logic [2:0]  f3;
    logic [31:0] ii, is, ib, iu, ij;
    f3 = in[14:12];
    ii = {{20{in[31]}}, in[31:20]};
    is = {{20{in[31]}}, in[31:25], in[11:7]};
    ib = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
    iu = {in[31:12], 12'b0};
    ij = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
    e = '0;
    e.pc = pc;
    e.a = a;
    e.b = b;
    jmp = 1'b0;
    tgt = 0;
    case (in[6:0])
      7'h33: begin e.rwr = 1; e.alu = {in[30], f3}; end
      7'h13: begin
        e.imm = ii; e.bsel = 1; e.rwr = 1;
        e.alu = {(f3 == 3'd5) ? in[30] : 1'b0, f3};
      end
      7'h03: begin e.imm = ii; e.bsel = 1; e.mrd = 1; e.rwr = 1; e.wb = 1; end
      7'h23: begin e.imm = is; e.bsel = 1; e.mwr = 1; end
      7'h63: begin
        e.imm = ib;
        tgt = pc + ib;
        case (f3)
          3'd0: jmp = (a == b);
          3'd1: jmp = (a != b);
          3'd4: jmp = ($signed(a) < $signed(b));
          3'd5: jmp = ($signed(a) >= $signed(b));
          3'd6: jmp = (a < b);
          3'd7: jmp = (a >= b);
          default: jmp = 0;
        endcase
      end
      7'h6f: begin
        e.imm = ij; e.asel = 1; e.bsel = 1; e.rwr = 1; e.wb = 2;
        jmp = 1; tgt = pc + ij;
      end
      7'h67: begin
        e.imm = ii; e.bsel = 1; e.rwr = 1; e.wb = 2;
        jmp = 1; tgt = (a + ii) & ~32'd1;
      end
      7'h37: begin e.imm = iu; e.bsel = 1; e.rwr = 1; end
      7'h17: begin e.imm = iu; e.asel = 1; e.bsel = 1; e.rwr = 1; end
      default: ;
    endcase
    if (e.rwr) e.rd = in[11:7];
    if (!jmp) tgt = 0;
  endfunction

  task automatic model_cycle();
    exp_t        e;
    logic        jmp, acc;
    logic [31:0] a, b, tgt;
    acc = if_valid && if_ready;
    a = fwdv(fwd_sel1, rdrf(if_inst[19:15]));
    b = fwdv(fwd_sel2, rdrf(if_inst[24:20]));
    model(if_inst, if_pc, a, b, e, jmp, tgt);
    if (acc && !m_kill) begin
      q.push_back(e);
      chk("redirect", {redirect, redirect_pc}, {jmp, tgt});
      m_kill = jmp;
    end else begin
      chk("no_redirect", {redirect, redirect_pc}, 0);
      if (acc) m_kill = 1'b0;
    end
    if (wb_wr_en && wb_rd != 0) rf[wb_rd] = wb_data;
  endtask

  task automatic step();
    @(negedge clk);
    obs_ready = if_ready;
    obs_redir = redirect;
    obs_rpc   = redirect_pc;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 0;
    wb_wr_en = 0;
    fwd_sel1 = 0;
    fwd_sel2 = 0;
    ex_ready = 1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    idle();
    wb_wr_en = 1;
    wb_rd = r;
    wb_data = d;
    step();
    wb_wr_en = 0;
  endtask

  task automatic issue(input logic [31:0] in, input logic [31:0] pc,
                       input logic er);
    idle();
    if_valid = 1;
    if_inst = in;
    if_pc = pc;
    ex_ready = er;
    step();
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, rs1,
      input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm,
      input logic [4:0] rs2, rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [2:0]  bf [6];
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    r = $urandom;
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    r[11:7]  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 8))
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h23;
      3: begin r[6:0] = 7'h63; r[14:12] = bf[$urandom_range(0, 5)]; end
      4: r[6:0] = 7'h6f;
      5: begin r[6:0] = 7'h67; r[14:12] = 3'd0; end
      6: r[6:0] = 7'h37;
      7: r[6:0] = 7'h17;
      default: r[6:0] = ($urandom_range(0, 1) != 0) ? 7'h0f : 7'h7f;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t act;
    if (!reset && id_ex_valid && ex_ready) begin
      act = {id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
             id_ex_rd, id_ex_alu_op, id_ex_asel, id_ex_bsel,
             id_ex_mem_rd, id_ex_mem_wr, id_ex_reg_wr, id_ex_wb_sel};
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: got pc %h expected no instruction",
                 id_ex_pc);
      end else begin
        chk("idex", act, q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    @(posedge clk);
    #1;
    chk("rst_valid", id_ex_valid, 0);
    chk("rst_ready", if_ready, 1);
    chk("rst_redirect", {redirect, redirect_pc}, 0);
    chk("rst_fields", {id_ex_pc, id_ex_rd, id_ex_reg_wr, id_ex_wb_sel}, 0);

    issue(enc_i(5, 0, 0, 1, 7'h13), 32'h40, 1);
    chk("addi_valid", id_ex_valid, 1);
    chk("addi_imm", id_ex_imm, 5);
    chk("addi_rd", id_ex_rd, 1);
    chk("addi_rwr", id_ex_reg_wr, 1);
    chk("addi_bsel", id_ex_bsel, 1);

    if_valid = 1;
    if_inst = enc_r(0, 3, 0, 4);
    if_pc = 32'h44;
    wb_wr_en = 1;
    wb_rd = 3;
    wb_data = 32'hA5;
    step();
    chk("bypass_rs1", id_ex_rs1_data, 32'hA5);
    wr(0, 32'h55);
    issue(enc_r(0, 0, 0, 7), 32'h48, 1);
    chk("x0_reads_0", id_ex_rs1_data, 0);

    wr(1, 7);
    wr(2, 7);
    issue(enc_b(32'h20, 2, 1, 3'd0), 32'h100, 1);
    chk("beq_redirect", {obs_redir, obs_rpc}, {1'b1, 32'h120});
    issue({1'b0, 10'd8, 1'b0, 8'd0, 5'd1, 7'h6f}, 32'h104, 1);
    chk("kill_no_redirect", obs_redir, 0);
    chk("kill_bubble", id_ex_valid, 0);
    wr(3, 32'hFFFF_FFFF);
    wr(4, 1);
    issue(enc_b(32'h40, 4, 3, 3'd6), 32'h108, 1);
    chk("bltu_not_taken", obs_redir, 0);

    wr(2, 32'h200);
    issue(enc_i(7, 2, 0, 1, 7'h67), 32'h300, 1);
    chk("jalr_target", {obs_redir, obs_rpc}, {1'b1, 32'h206});
    chk("jalr_wbsel", id_ex_wb_sel, 2);
    for (int i = 0; i < 3; i++) begin
      issue(enc_i(1, 0, 0, 9, 7'h13), 32'h304, 0);
      chk("hold_ready", obs_ready, 0);
      chk("hold_idex", {id_ex_valid, id_ex_pc, id_ex_rd, id_ex_wb_sel},
          {1'b1, 32'h300, 5'd1, 2'd2});
    end
    issue(enc_i(1, 0, 0, 9, 7'h13), 32'h304, 1);
    chk("hold_release_kill", {obs_ready, obs_redir, id_ex_valid}, 3'b100);

    idle();
    step();
    issue(enc_i(0, 0, 3'd2, 5, 7'h03), 32'h400, 1);
    chk("lw_in_idex", {id_ex_valid, id_ex_mem_rd, id_ex_rd}, {2'b11, 5'd5});
    issue(enc_r(5, 5, 0, 6), 32'h404, 1);
    chk("stall1_ready", {obs_ready, id_ex_valid}, 0);
    issue(enc_r(5, 5, 0, 6), 32'h404, 1);
    chk("stall2_ready", {obs_ready, id_ex_valid}, 0);
    issue(enc_r(5, 5, 0, 6), 32'h404, 1);
    chk("stall_release", {obs_ready, id_ex_valid, id_ex_rd}, {2'b11, 5'd6});

    issue(enc_i(0, 0, 3'd2, 5, 7'h03), 32'h500, 1);
    issue(enc_r(5, 5, 0, 6), 32'h504, 1);
    chk("stall_again", obs_ready, 0);
    reset = 1;
    #1;
    chk("midstall_rst_valid", id_ex_valid, 0);
    #2;
    reset = 0;
    q.delete();
    m_kill = 0;
    for (int i = 0; i < 32; i++) rf[i] = 0;
    chk("after_rst_ready", if_ready, 1);
    issue(enc_r(5, 5, 0, 6), 32'h504, 1);
    chk("after_rst_accept", {obs_ready, id_ex_valid}, 2'b11);

    for (int n = 0; n < 400; n++) begin
      if_valid   = ($urandom_range(0, 9) < 8);
      if_inst    = rand_inst();
      if_pc      = $urandom & ~32'd3;
      ex_ready   = ($urandom_range(0, 3) != 0);
      wb_wr_en   = $urandom_range(0, 1) != 0;
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      fwd_sel1   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
      fwd_sel2   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
      ex_alu_out = $urandom;
      mem_data   = $urandom;
      step();
    end

    idle();
    repeat (4) step();
    chk("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
